decode_stage: RTL

//  Registered, parametrised instruction decode stage. Splits {opcode,dest,src} into fields
//  and holds them in an output register under a valid/ready handshake.
//  A per-register busy scoreboard stalls any instruction whose src or dest register is still

---
 rtl/decode_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with per-register busy scoreboard
// Optional macro WB_BYPASS_EN: a same-cycle writeback releases a dependent instruction.
module decode_stage #(
  parameter  int OPC_W   = 3,
  parameter  int REG_W   = 3,
  parameter  int STALL_W = 8,
  localparam int INSTR_W = OPC_W + 2*REG_W,
  localparam int NREG    = 2**REG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [OPC_W-1:0]   dec_opcode,
  output logic [REG_W-1:0]   dec_dest,
  output logic [REG_W-1:0]   dec_src,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_reg,
  output logic [NREG-1:0]    busy,
  output logic [STALL_W-1:0] stall_cnt
);

  logic               r_dec_valid;
  logic [OPC_W-1:0]   r_opcode;
  logic [REG_W-1:0]   r_dest;
  logic [REG_W-1:0]   r_src;
  logic [NREG-1:0]    r_busy;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [OPC_W-1:0]   w_opcode;
  logic [REG_W-1:0]   w_dest;
  logic [REG_W-1:0]   w_src;
  logic [NREG-1:0]    w_wb_onehot;
  logic [NREG-1:0]    w_set_onehot;
  logic [NREG-1:0]    w_busy_eff;
  logic [NREG-1:0]    w_busy_next;
  logic               w_hazard;
  logic               w_issue;
  logic               w_stall;

  assign w_opcode = instr[INSTR_W-1 -: OPC_W];
  assign w_dest   = instr[2*REG_W-1 -: REG_W];
  assign w_src    = instr[REG_W-1:0];

  assign w_wb_onehot = wb_valid ? (NREG'(1) << wb_reg) : '0;

`ifdef WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wb_onehot;
`else
  assign w_busy_eff = r_busy;
`endif

  assign w_hazard    = instr_valid & (w_busy_eff[w_src] | w_busy_eff[w_dest]);
  assign instr_ready = (~r_dec_valid | dec_ready) & ~w_hazard;
  assign w_issue     = instr_valid & instr_ready;
  assign w_stall     = instr_valid & ~instr_ready;

  // Set is OR-ed in after the clear so an issuing dest beats a same-cycle writeback.
  assign w_set_onehot = w_issue ? (NREG'(1) << w_dest) : '0;
  assign w_busy_next  = (r_busy & ~w_wb_onehot) | w_set_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_valid <= 1'b0;
      r_opcode    <= '0;
      r_dest      <= '0;
      r_src       <= '0;
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_issue) begin
        r_dec_valid <= 1'b1;
        r_opcode    <= w_opcode;
        r_dest      <= w_dest;
        r_src       <= w_src;
      end else if (dec_ready) begin
        r_dec_valid <= 1'b0;
      end
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  assign dec_valid  = r_dec_valid;
  assign dec_opcode = r_opcode;
  assign dec_dest   = r_dest;
  assign dec_src    = r_src;
  assign busy       = r_busy;
  assign stall_cnt  = r_stall_cnt;

endmodule
